// File: rtl/dlsc_pxdma_pkg.sv
// Shared pixel-DMA definitions: packer/unpacker state encodings, the
// bytes-per-pixel decode and the byte-lane strobe mask helper.
package dlsc_pxdma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } px_state_t;

    localparam int unsigned BUF_BYTES = 8;

    function automatic logic [2:0] bpw_to_bytes(input logic [1:0] bpw);
        return {1'b0, bpw} + 3'd1;
    endfunction

    // Lanes lane .. lane+bytes-1 of the 8-byte staging buffer.
    function automatic logic [7:0] strb_mask(input logic [2:0] lane, input logic [2:0] bytes);
        logic [7:0] m;
        logic [3:0] lo;
        logic [3:0] hi;
        lo = {1'b0, lane};
        hi = lo + {1'b0, bytes};
        m  = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if ((4'(j) >= lo) && (4'(j) < hi)) begin
                m[j] = 1'b1;
            end else begin
                m[j] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/dlsc_px_packer_insert.sv
// Combinational insertion of up to 4 pixel bytes at byte lane 'lane' of the
// 8-byte staging buffer, setting the matching strobe bits.
module dlsc_px_packer_insert
    import dlsc_pxdma_pkg::*;
(
    input  logic [63:0] buf_in,
    input  logic [7:0]  sb_in,
    input  logic [2:0]  lane,
    input  logic [2:0]  bytes,
    input  logic [31:0] data,
    output logic [63:0] buf_out,
    output logic [7:0]  sb_out
);

    logic [7:0] mask_s;
    logic [2:0] rel_s;

    // Per-lane mux: lanes inside the mask take pixel byte (lane_index - lane).
    always_comb begin
        buf_out = buf_in;
        sb_out  = sb_in;
        rel_s   = 3'd0;
        mask_s  = strb_mask(lane, bytes);
        for (int j = 0; j < 8; j++) begin
            rel_s = 3'(j) - lane;
            if (mask_s[j]) begin
                buf_out[j*8 +: 8] = data[{rel_s[1:0], 3'b000} +: 8];
                sb_out[j]         = 1'b1;
            end else begin
                buf_out[j*8 +: 8] = buf_in[j*8 +: 8];
                sb_out[j]         = sb_in[j];
            end
        end
    end

endmodule

// File: rtl/dlsc_px_packer.sv
// Packs 1-4 byte pixels into 32-bit little-endian words with strobes, one row
// per command. Optional DLSC_PX_PACKER_ZERO_PAD_EN zeroes unstrobed out_data bytes.
module dlsc_px_packer
    import dlsc_pxdma_pkg::*;
#(
    parameter int WLEN = 11
) (
    input  logic            clk,
    input  logic            rst,
    output logic            cmd_ready,
    input  logic            cmd_valid,
    input  logic [1:0]      cmd_offset,
    input  logic [1:0]      cmd_bpw,
    input  logic [WLEN-1:0] cmd_words,
    output logic            cmd_done,
    output logic            in_ready,
    input  logic            in_valid,
    input  logic [31:0]     in_data,
    input  logic            out_ready,
    output logic            out_valid,
    output logic            out_last,
    output logic [31:0]     out_data,
    output logic [3:0]      out_strb
);

    localparam logic [WLEN-1:0] LEFT_ONE = WLEN'(1);

    px_state_t       state_r, state_nxt;
    logic [3:0]      f_r, f_nxt;
    logic [63:0]     buf_r, buf_nxt;
    logic [7:0]      sb_r, sb_nxt;
    logic [WLEN-1:0] left_r, left_nxt;
    logic [2:0]      bytes_r, bytes_nxt;
    logic            done_r, done_nxt;

    logic            pop_s;
    logic            in_fire_s;
    logic [3:0]      f_shift_s;
    logic [63:0]     buf_shift_s;
    logic [7:0]      sb_shift_s;
    logic [63:0]     buf_ins_s;
    logic [7:0]      sb_ins_s;

    // Handshake decode; everything except in_ready comes from registered state.
    always_comb begin
        cmd_ready = (state_r == ST_IDLE);
        out_valid = (f_r >= 4'd4) || ((state_r == ST_FLUSH) && (f_r != 4'd0));
        out_last  = (state_r == ST_FLUSH) && (f_r <= 4'd4);
        out_strb  = sb_r[3:0];
        cmd_done  = done_r;
        pop_s     = out_valid && out_ready;
        if (pop_s) begin
            f_shift_s   = (f_r >= 4'd4) ? (f_r - 4'd4) : 4'd0;
            buf_shift_s = {32'h0000_0000, buf_r[63:32]};
            sb_shift_s  = {4'h0, sb_r[7:4]};
        end else begin
            f_shift_s   = f_r;
            buf_shift_s = buf_r;
            sb_shift_s  = sb_r;
        end
        in_ready  = (state_r == ST_ACTIVE) && (f_shift_s <= 4'd4);
        in_fire_s = in_ready && in_valid;
    end

`ifdef DLSC_PX_PACKER_ZERO_PAD_EN
    // Unstrobed lanes are forced to zero.
    always_comb begin
        out_data = 32'h0000_0000;
        for (int j = 0; j < 4; j++) begin
            if (sb_r[j]) begin
                out_data[j*8 +: 8] = buf_r[j*8 +: 8];
            end else begin
                out_data[j*8 +: 8] = 8'h00;
            end
        end
    end
`else
    // Unstrobed lanes carry whatever the buffer holds.
    always_comb begin
        out_data = buf_r[31:0];
    end
`endif

    // New bytes land after the pop shift, at the post-shift fill pointer.
    dlsc_px_packer_insert u_insert (
        .buf_in  (buf_shift_s),
        .sb_in   (sb_shift_s),
        .lane    (f_shift_s[2:0]),
        .bytes   (bytes_r),
        .data    (in_data),
        .buf_out (buf_ins_s),
        .sb_out  (sb_ins_s)
    );

    // Row FSM: next state, pointer, counter and done pulse.
    always_comb begin
        state_nxt = state_r;
        f_nxt     = f_shift_s;
        buf_nxt   = buf_shift_s;
        sb_nxt    = sb_shift_s;
        left_nxt  = left_r;
        bytes_nxt = bytes_r;
        done_nxt  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    f_nxt     = {2'b00, cmd_offset};
                    sb_nxt    = 8'h00;
                    left_nxt  = cmd_words;
                    bytes_nxt = bpw_to_bytes(cmd_bpw);
                    if (cmd_words == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_ACTIVE;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (in_fire_s) begin
                    buf_nxt  = buf_ins_s;
                    sb_nxt   = sb_ins_s;
                    f_nxt    = f_shift_s + {1'b0, bytes_r};
                    left_nxt = left_r - LEFT_ONE;
                    if (left_r == LEFT_ONE) begin
                        state_nxt = ST_FLUSH;
                    end else begin
                        state_nxt = ST_ACTIVE;
                    end
                end else begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_FLUSH: begin
                if (pop_s && (f_shift_s == 4'd0)) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_FLUSH;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                f_nxt     = 4'd0;
                sb_nxt    = 8'h00;
            end
        endcase
    end

    // State registers with synchronous reset; a reset drops any partial row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            f_r     <= 4'd0;
            buf_r   <= 64'd0;
            sb_r    <= 8'h00;
            left_r  <= '0;
            bytes_r <= 3'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            f_r     <= f_nxt;
            buf_r   <= buf_nxt;
            sb_r    <= sb_nxt;
            left_r  <= left_nxt;
            bytes_r <= bytes_nxt;
            done_r  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_dlsc_px_packer.sv
// Self-checking bench for dlsc_px_packer: directed rows plus randomized rows
// checked against a byte-list reference model.
module tb_dlsc_px_packer;

    localparam int WLEN = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_ready;
    logic            cmd_valid;
    logic [1:0]      cmd_offset;
    logic [1:0]      cmd_bpw;
    logic [WLEN-1:0] cmd_words;
    logic            cmd_done;
    logic            in_ready;
    logic            in_valid;
    logic [31:0]     in_data;
    logic            out_ready;
    logic            out_valid;
    logic            out_last;
    logic [31:0]     out_data;
    logic [3:0]      out_strb;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    logic [31:0] pix_q[$];
    logic [31:0] pix_given[$];
    int          n_checks = 0;
    int          n_err    = 0;

    dlsc_px_packer #(.WLEN(WLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_offset (cmd_offset),
        .cmd_bpw    (cmd_bpw),
        .cmd_words  (cmd_words),
        .cmd_done   (cmd_done),
        .in_ready   (in_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_data   (out_data),
        .out_strb   (out_strb)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Row as a flat byte list: offset pads, pixel bytes, tail pads; every 4 bytes is a word.
    task automatic build_expected(input int offset, input int bpw, input int count);
        logic [7:0]  bq[$];
        logic        sq[$];
        logic [31:0] px;
        word_t       wd;
        int          nw;
        exp_q.delete();
        if (count > 0) begin
            for (int i = 0; i < offset; i++) begin
                bq.push_back(8'h00);
                sq.push_back(1'b0);
            end
            for (int p = 0; p < pix_q.size(); p++) begin
                px = pix_q[p];
                for (int k = 0; k <= bpw; k++) begin
                    bq.push_back(px[k*8 +: 8]);
                    sq.push_back(1'b1);
                end
            end
            while ((bq.size() % 4) != 0) begin
                bq.push_back(8'h00);
                sq.push_back(1'b0);
            end
            nw = bq.size() / 4;
            for (int w = 0; w < nw; w++) begin
                for (int k = 0; k < 4; k++) begin
                    wd.data[k*8 +: 8] = bq[w*4 + k];
                    wd.strb[k]        = sq[w*4 + k];
                end
                wd.last = (w == nw - 1);
                exp_q.push_back(wd);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 0: out_ready=1, in_valid=1; mode 1: random; mode 2: out_ready low for 10 cycles.
    task automatic run_row(input int offset, input int bpw, input int count, input int mode);
        logic        exp_done;
        logic [31:0] m;
        int          cyc;
        int          acc;
        pix_q.delete();
        if (pix_given.size() == count) begin
            pix_q = pix_given;
        end else begin
            for (int i = 0; i < count; i++) pix_q.push_back($urandom);
        end
        pix_given.delete();
        build_expected(offset, bpw, count);

        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_offset = 2'(offset);
        cmd_bpw    = 2'(bpw);
        cmd_words  = WLEN'(count);
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        #1;
        check_val("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        exp_done = (count == 0);
        cyc = 0;
        acc = 0;
        forever begin
            @(negedge clk);
            cmd_valid  = exp_done ? 1'b0 : 1'($urandom_range(0, 1));
            cmd_offset = 2'($urandom);
            cmd_bpw    = 2'($urandom);
            cmd_words  = WLEN'($urandom);
            case (mode)
                0: begin out_ready = 1'b1; in_valid = 1'b1; end
                2: begin out_ready = (cyc >= 10); in_valid = 1'b1; end
                default: begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    in_valid  = ($urandom_range(0, 3) != 0);
                end
            endcase
            in_data = (pix_q.size() > 0) ? pix_q[0] : $urandom;
            #1;
            check_val("cmd_done", 32'(cmd_done), 32'(exp_done));
            if (exp_done) begin
                check_val("cmd_ready_after_row", 32'(cmd_ready), 32'd1);
                check_val("idle_out_valid", 32'(out_valid), 32'd0);
                in_valid = 1'b0;
                break;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
`ifdef DLSC_PX_PACKER_ZERO_PAD_EN
                    m = 32'hFFFF_FFFF;
`else
                    for (int k = 0; k < 4; k++) m[k*8 +: 8] = exp_q[0].strb[k] ? 8'hFF : 8'h00;
`endif
                    check_val("out_data", out_data & m, exp_q[0].data & m);
                    check_val("out_strb", 32'(out_strb), 32'(exp_q[0].strb));
                    check_val("out_last", 32'(out_last), 32'(exp_q[0].last));
                    if (out_ready) begin
                        if (exp_q[0].last) exp_done = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (mode == 0 && pix_q.size() > 0)
                check_val("throughput_in_ready", 32'(in_ready), 32'd1);
            if (mode == 2 && cyc < 10)
                check_val("stall_in_ready", 32'(in_ready), (acc < 2) ? 32'd1 : 32'd0);
            if (in_valid && in_ready) begin
                if (pix_q.size() == 0) begin
                    check_val("accept_outside_active", 32'd1, 32'd0);
                end else begin
                    void'(pix_q.pop_front());
                    acc++;
                end
            end
            cyc++;
            if (cyc > 2000) begin
                check_val("row_timeout", 32'd0, 32'd1);
                apply_reset();
                break;
            end
        end
        check_val("words_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Reset after 2 of 5 pixels must discard the row silently.
    task automatic reset_midrow();
        int acc = 0;
        int cyc = 0;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_offset = 2'($urandom);
        cmd_bpw    = 2'($urandom);
        cmd_words  = WLEN'(5);
        @(negedge clk);
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        while (acc < 2 && cyc < 50) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            #1;
            if (in_ready) acc++;
            @(negedge clk);
            cyc++;
        end
        check_val("midrow_accepts", 32'(acc), 32'd2);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("rst_cmd_done", 32'(cmd_done), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        check_val("rst_cmd_done_later", 32'(cmd_done), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_offset = 2'd0;
        cmd_bpw    = 2'd0;
        cmd_words  = '0;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("reset_in_ready", 32'(in_ready), 32'd0);
        check_val("reset_out_valid", 32'(out_valid), 32'd0);
        check_val("reset_out_last", 32'(out_last), 32'd0);
        check_val("reset_out_data", out_data, 32'd0);
        check_val("reset_out_strb", 32'(out_strb), 32'd0);
        check_val("reset_cmd_done", 32'(cmd_done), 32'd0);

        pix_given = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
        run_row(0, 3, 3, 0);
        pix_given = '{32'h0003_0201, 32'h0006_0504, 32'h0009_0807, 32'h000C_0B0A};
        run_row(0, 2, 4, 0);
        pix_given = '{32'h0000_00AA, 32'h0000_00BB};
        run_row(3, 0, 2, 0);
        run_row(0, 3, 4, 2);
        run_row(2, 1, 0, 1);
        reset_midrow();
        run_row(1, 1, 5, 1);

        for (int r = 0; r < 40; r++)
            run_row($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
